// File: rtl/midi_pkg.sv
// Shared MIDI frame constants for the SPI bridge.
// Frames go out LSB first, so the status byte sits in the low bits.
package midi_pkg;
  localparam int DEF_MSG_BITS = 24;
  localparam logic [7:0] MIDI_NOTE_ON  = 8'h90;
  localparam logic [7:0] MIDI_NOTE_OFF = 8'h80;
  localparam logic [DEF_MSG_BITS-1:0] NULL_FRAME = '0;

  function automatic logic [DEF_MSG_BITS-1:0] midi_frame(input logic [7:0] st,
                                                         input logic [7:0] d1,
                                                         input logic [7:0] d2);
    return {d2, d1, st};
  endfunction
endpackage

// File: rtl/midi_frame_fifo.sv
// First-word-fall-through frame FIFO; pushes while full and pops while empty are ignored.
module midi_frame_fifo
  import midi_pkg::*;
#(
  parameter int WIDTH = DEF_MSG_BITS,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  output logic                     o_full,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [AW:0]      r_cnt;
  logic             w_push, w_pop;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_dout  = r_mem[r_rd];
  assign o_level = r_cnt;
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end
endmodule

// File: rtl/spi_midi_bridge.sv
// SPI slave carrying back-to-back MIDI frames; TX/RX frames are queued so the
// downstream pipeline only sees valid/ready handshakes.
module spi_midi_bridge
  import midi_pkg::*;
#(
  parameter int MSG_BITS    = DEF_MSG_BITS,
  parameter int TX_DEPTH    = 8,
  parameter int RX_DEPTH    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_spi_csn,
  input  logic                      i_spi_clk,
  input  logic                      i_spi_mosi,
  output logic                      o_spi_miso,
  input  logic                      i_spi_write_en,
  input  logic                      i_tx_valid,
  input  logic [MSG_BITS-1:0]       i_tx_data,
  output logic                      o_tx_ready,
  output logic                      o_rx_valid,
  output logic [MSG_BITS-1:0]       o_rx_data,
  input  logic                      i_rx_ready,
  output logic                      o_read_needed,
  output logic [$clog2(TX_DEPTH):0] o_tx_level,
  output logic                      o_rx_overflow,
  input  logic                      i_overflow_clr
);
  localparam int CW  = $clog2(MSG_BITS);
  localparam int TLW = $clog2(TX_DEPTH) + 1;
  localparam int SW  = $clog2(SYNC_STAGES + 1) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;

  logic [SYNC_STAGES-1:0] r_csn_sync, r_sclk_sync, r_mosi_sync;
  logic                   r_csn_d, r_sclk_d;
  logic [SW-1:0]          r_settle;
  logic                   r_armed;
  logic [1:0]             r_state;
  logic [CW-1:0]          r_bitcnt;
  logic [MSG_BITS-1:0]    r_shift_in, r_shift_out;
  logic                   r_live, r_load, r_ovf, r_read_needed;

  logic                   w_csn_s, w_sclk_s, w_mosi_s;
  logic                   w_csn_fall, w_rise, w_last;
  logic [MSG_BITS-1:0]    w_shift_in_nxt;
  logic                   w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
  logic [MSG_BITS-1:0]    w_tx_dout;
  logic [TLW-1:0]         w_tx_lvl_nxt;
  logic                   w_rx_push, w_rx_pop, w_rx_full, w_rx_empty, w_rx_drop;
  logic [$clog2(RX_DEPTH):0] w_unused_rx_level;

  assign w_csn_s        = r_csn_sync[SYNC_STAGES-1];
  assign w_sclk_s       = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi_s       = r_mosi_sync[SYNC_STAGES-1];
  assign w_csn_fall     = ~w_csn_s & r_csn_d;
  assign w_rise         = w_sclk_s & ~r_sclk_d & ~w_csn_s;
  assign w_last         = (r_bitcnt == CW'(MSG_BITS - 1));
  assign w_shift_in_nxt = {w_mosi_s, r_shift_in[MSG_BITS-1:1]};

  assign w_tx_push    = i_tx_valid & ~w_tx_full;
  assign w_tx_pop     = w_rise & (r_state == S_READ) & w_last & r_live;
  assign w_tx_lvl_nxt = o_tx_level + TLW'(w_tx_push) - TLW'(w_tx_pop & ~w_tx_empty);
  assign w_rx_push    = w_rise & (r_state == S_WRITE) & w_last;
  assign w_rx_drop    = w_rx_push & w_rx_full;
  assign w_rx_pop     = o_rx_valid & i_rx_ready;

  assign o_tx_ready    = ~w_tx_full;
  assign o_rx_valid    = ~w_rx_empty;
  assign o_read_needed = r_read_needed;
  assign o_rx_overflow = r_ovf;
  assign o_spi_miso    = (r_state == S_READ) & ~w_csn_s & r_shift_out[0];

  midi_frame_fifo #(.WIDTH(MSG_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset),
    .i_push(w_tx_push), .i_din(i_tx_data), .o_full(w_tx_full),
    .i_pop(w_tx_pop), .o_dout(w_tx_dout), .o_empty(w_tx_empty),
    .o_level(o_tx_level)
  );

  midi_frame_fifo #(.WIDTH(MSG_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset),
    .i_push(w_rx_push), .i_din(w_shift_in_nxt), .o_full(w_rx_full),
    .i_pop(w_rx_pop), .o_dout(o_rx_data), .o_empty(w_rx_empty),
    .o_level(w_unused_rx_level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_csn_sync    <= '1;
      r_sclk_sync   <= '0;
      r_mosi_sync   <= '0;
      r_csn_d       <= 1'b1;
      r_sclk_d      <= 1'b0;
      r_settle      <= '0;
      r_armed       <= 1'b0;
      r_state       <= S_IDLE;
      r_bitcnt      <= '0;
      r_shift_in    <= '0;
      r_shift_out   <= '0;
      r_live        <= 1'b0;
      r_load        <= 1'b0;
      r_ovf         <= 1'b0;
      r_read_needed <= 1'b0;
    end else begin
      r_csn_sync  <= {r_csn_sync[SYNC_STAGES-2:0], i_spi_csn};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_spi_clk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
      r_csn_d     <= w_csn_s;
      r_sclk_d    <= w_sclk_s;
      // Synchroniser preset looks like csn high; only trust it once flushed,
      // so a csn held low through reset never opens a transaction.
      if (r_settle != SW'(SYNC_STAGES)) r_settle <= r_settle + 1'b1;
      else if (w_csn_s)                 r_armed  <= 1'b1;

      r_read_needed <= (w_tx_lvl_nxt != '0);
      if (w_rx_drop)           r_ovf <= 1'b1;
      else if (i_overflow_clr) r_ovf <= 1'b0;

      // Reload one cycle after entry/pop so the FWFT head has settled.
      r_load <= 1'b0;
      if (r_load) begin
        r_shift_out <= w_tx_empty ? '0 : w_tx_dout;
        r_live      <= ~w_tx_empty;
      end

      case (r_state)
        S_IDLE: begin
          if (w_csn_fall && r_armed) begin
            r_bitcnt <= '0;
            if (i_spi_write_en) r_state <= S_WRITE;
            else begin
              r_state <= S_READ;
              r_load  <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (w_csn_s) r_state <= S_IDLE;
          else if (w_rise) begin
            r_shift_in <= w_shift_in_nxt;
            r_bitcnt   <= w_last ? '0 : r_bitcnt + 1'b1;
          end
        end
        S_READ: begin
          if (w_csn_s) r_state <= S_IDLE;
          else if (w_rise) begin
            r_shift_out <= r_shift_out >> 1;
            if (w_last) begin
              r_bitcnt <= '0;
              r_load   <= 1'b1;
            end else begin
              r_bitcnt <= r_bitcnt + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_midi_bridge.sv
// Randomised bench for spi_midi_bridge against a queue-based frame model.
module tb_spi_midi_bridge;
  import midi_pkg::*;
  localparam int MB  = 24;
  localparam int TXD = 8;
  localparam int RXD = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_spi_csn = 1'b1, i_spi_clk = 1'b0, i_spi_mosi = 1'b0, i_spi_write_en = 1'b0;
  logic          o_spi_miso;
  logic          i_tx_valid = 1'b0;
  logic [MB-1:0] i_tx_data = '0;
  logic          o_tx_ready, o_rx_valid;
  logic [MB-1:0] o_rx_data;
  logic          i_rx_ready = 1'b0;
  logic          o_read_needed;
  logic [3:0]    o_tx_level;
  logic          o_rx_overflow;
  logic          i_overflow_clr = 1'b0;

  always #5 clk = ~clk;

  spi_midi_bridge #(.MSG_BITS(MB), .TX_DEPTH(TXD), .RX_DEPTH(RXD), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset),
    .i_spi_csn(i_spi_csn), .i_spi_clk(i_spi_clk), .i_spi_mosi(i_spi_mosi),
    .o_spi_miso(o_spi_miso), .i_spi_write_en(i_spi_write_en),
    .i_tx_valid(i_tx_valid), .i_tx_data(i_tx_data), .o_tx_ready(o_tx_ready),
    .o_rx_valid(o_rx_valid), .o_rx_data(o_rx_data), .i_rx_ready(i_rx_ready),
    .o_read_needed(o_read_needed), .o_tx_level(o_tx_level),
    .o_rx_overflow(o_rx_overflow), .i_overflow_clr(i_overflow_clr)
  );

  int            n_chk = 0, n_err = 0;
  logic [MB-1:0] txq[$];
  logic [MB-1:0] rxq[$];
  bit            ovf_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [MB-1:0] rnd_frame();
    logic [31:0] r;
    r = $urandom;
    return r[MB-1:0];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bit(input logic b, output logic so);
    i_spi_mosi = b;
    tick(4);
    so = o_spi_miso;
    i_spi_clk = 1'b1;
    tick(4);
    i_spi_clk = 1'b0;
  endtask

  task automatic spi_begin(input logic wr);
    i_spi_write_en = wr;
    i_spi_csn = 1'b0;
    tick(6);
  endtask

  task automatic spi_end();
    tick(4);
    i_spi_csn = 1'b1;
    tick(6);
  endtask

  task automatic write_frame(input logic [MB-1:0] w);
    logic so;
    for (int i = 0; i < MB; i++) spi_bit(w[i], so);
    if (rxq.size() < RXD) rxq.push_back(w);
    else ovf_m = 1'b1;
  endtask

  task automatic read_check(input string tag);
    logic [MB-1:0] w, exp;
    logic so;
    exp = (txq.size() != 0) ? txq[0] : NULL_FRAME;
    for (int i = 0; i < MB; i++) begin
      spi_bit(1'b0, so);
      w[i] = so;
    end
    if (txq.size() != 0) void'(txq.pop_front());
    tick(2);
    chk(tag, 32'(w), 32'(exp));
    chk("tx_level_read", 32'(o_tx_level), 32'(txq.size()));
    chk("read_needed_read", 32'(o_read_needed), 32'(txq.size() != 0));
  endtask

  task automatic tx_push(input logic [MB-1:0] w);
    bit acc;
    acc = (txq.size() < TXD);
    i_tx_valid = 1'b1;
    i_tx_data  = w;
    @(posedge clk);
    #1;
    i_tx_valid = 1'b0;
    if (acc) txq.push_back(w);
    chk("tx_level_push", 32'(o_tx_level), 32'(txq.size()));
    chk("tx_ready", 32'(o_tx_ready), 32'(txq.size() < TXD));
    chk("read_needed_push", 32'(o_read_needed), 32'(txq.size() != 0));
  endtask

  task automatic rx_drain(input string tag);
    while (rxq.size() != 0) begin
      chk("rx_valid", 32'(o_rx_valid), 32'(1));
      chk(tag, 32'(o_rx_data), 32'(rxq[0]));
      i_rx_ready = 1'b1;
      @(posedge clk);
      #1;
      i_rx_ready = 1'b0;
      void'(rxq.pop_front());
    end
    chk("rx_valid_empty", 32'(o_rx_valid), 32'(0));
  endtask

  initial begin
    logic so;
    int n;
    tick(3);
    reset = 1'b0;
    tick(4);

    chk("rst_miso", 32'(o_spi_miso), 32'(0));
    chk("rst_tx_ready", 32'(o_tx_ready), 32'(1));
    chk("rst_rx_valid", 32'(o_rx_valid), 32'(0));
    chk("rst_read_needed", 32'(o_read_needed), 32'(0));
    chk("rst_tx_level", 32'(o_tx_level), 32'(0));
    chk("rst_rx_overflow", 32'(o_rx_overflow), 32'(0));

    // write burst; write_en flips mid-transaction and must be ignored
    spi_begin(1'b1);
    i_spi_write_en = 1'b0;
    write_frame(midi_frame(MIDI_NOTE_ON, 8'h3C, 8'h7F));
    write_frame(midi_frame(MIDI_NOTE_OFF, 8'h3C, 8'h00));
    write_frame(midi_frame(MIDI_NOTE_ON, 8'h40, 8'h7F));
    spi_end();
    chk("burst_overflow", 32'(o_rx_overflow), 32'(ovf_m));
    rx_drain("burst_rx_data");

    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(1, 3);
      spi_begin(1'b1);
      for (int j = 0; j < n; j++) write_frame(rnd_frame());
      spi_end();
      rx_drain("rand_rx_data");
    end

    // read drain: two frames then a null frame
    tx_push(rnd_frame());
    tx_push(rnd_frame());
    spi_begin(1'b0);
    for (int j = 0; j < 3; j++) read_check("drain_miso");
    spi_end();

    // partial read is resent in full
    tx_push(rnd_frame());
    spi_begin(1'b0);
    for (int j = 0; j < 10; j++) spi_bit(1'b0, so);
    spi_end();
    chk("partial_tx_level", 32'(o_tx_level), 32'(txq.size()));
    chk("partial_read_needed", 32'(o_read_needed), 32'(1));
    spi_begin(1'b0);
    read_check("partial_resend");
    spi_end();

    // partial write is discarded
    spi_begin(1'b1);
    for (int j = 0; j < 10; j++) spi_bit(1'($urandom), so);
    spi_end();
    chk("partial_wr_rx_valid", 32'(o_rx_valid), 32'(0));

    // RX overflow
    spi_begin(1'b1);
    for (int j = 0; j < RXD + 1; j++) write_frame(rnd_frame());
    spi_end();
    chk("ovf_set", 32'(o_rx_overflow), 32'(ovf_m));
    i_overflow_clr = 1'b1;
    tick(1);
    i_overflow_clr = 1'b0;
    ovf_m = 1'b0;
    chk("ovf_clr", 32'(o_rx_overflow), 32'(ovf_m));
    rx_drain("ovf_rx_data");

    // TX full: the extra offer must not land in the FIFO
    for (int j = 0; j < TXD + 1; j++) tx_push(rnd_frame());
    chk("full_tx_level", 32'(o_tx_level), 32'(TXD));
    spi_begin(1'b0);
    for (int j = 0; j < TXD + 1; j++) read_check("full_drain_miso");
    spi_end();

    // reset mid-write with csn held low
    tx_push(rnd_frame());
    spi_begin(1'b1);
    for (int j = 0; j < 12; j++) spi_bit(1'($urandom), so);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    txq.delete();
    rxq.delete();
    for (int j = 0; j < 24; j++) begin
      spi_bit(1'($urandom), so);
      if (o_rx_valid) chk("rst_mid_rx_valid", 32'(o_rx_valid), 32'(0));
    end
    tick(4);
    chk("rst_mid_rx_valid_end", 32'(o_rx_valid), 32'(0));
    chk("rst_mid_tx_level", 32'(o_tx_level), 32'(0));
    chk("rst_mid_read_needed", 32'(o_read_needed), 32'(0));
    i_spi_csn = 1'b1;
    tick(6);
    spi_begin(1'b1);
    write_frame(rnd_frame());
    spi_end();
    rx_drain("after_rst_rx_data");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
